addsub_serial: RTL and testbench



---
 rtl/addsub_serial.sv | 78 +++++++
 tb/tb_addsub_serial.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial add/sub, DIGIT bits per clk, ports clk/rst/in_valid/in_ready/a/b/sub/out_valid/out_ready/sum/carry/overflow, `ADDSUB_SAT_EN saturates signed overflow
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  localparam int N  = WIDTH / DIGIT;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum, w_shift, w_res;
  logic             r_c, r_carry, r_ovf, w_last, w_ovf;
  logic [KW-1:0]    r_k;
  logic [DIGIT:0]   w_s;
  assign w_s     = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};
  assign w_last  = r_k == KW'(N - 1);
  assign w_shift = WIDTH'({w_s[DIGIT-1:0], r_sum} >> DIGIT);
  assign w_ovf   = (r_a[DIGIT-1] == r_b[DIGIT-1]) && (w_s[DIGIT-1] != r_a[DIGIT-1]);
`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(1) << (WIDTH - 1);
  assign w_res = w_ovf ? (r_a[DIGIT-1] ? SMIN : ~SMIN) : w_shift;
`else
  assign w_res = w_shift;
`endif
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next    = r_state;
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
    case (r_state)
      IDLE:    w_next = in_valid ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_k     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_a <= a;
      r_b <= sub ? ~b : b;
      r_c <= sub;
      r_k <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> DIGIT;
      r_b   <= r_b >> DIGIT;
      r_c   <= w_s[DIGIT];
      r_k   <= r_k + KW'(1);
      r_sum <= w_last ? w_res : w_shift;
      if (w_last) begin
        r_carry <= w_s[DIGIT];
        r_ovf   <= w_ovf;
      end
    end
  end
  assign sum      = r_sum;
  assign carry    = r_carry;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: scoreboarded random and directed checks of addsub_serial at 8/4 and 16/1
module tb_addsub_serial;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a[2], b[2], sum_w[2];
  logic        sub[2], iv[2], ir[2], ov[2], orr[2], cy[2], of[2];
  logic [7:0]  sum8;
  logic [15:0] sum16;
  logic [17:0] q0[$], q1[$];
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign sum_w[0] = {8'h00, sum8};
  assign sum_w[1] = sum16;
  addsub_serial #(.WIDTH(8), .DIGIT(4)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a[0][7:0]), .b(b[0][7:0]),
    .sub(sub[0]), .out_valid(ov[0]), .out_ready(orr[0]), .sum(sum8), .carry(cy[0]), .overflow(of[0]));
  addsub_serial #(.WIDTH(16), .DIGIT(1)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a[1]), .b(b[1]),
    .sub(sub[1]), .out_valid(ov[1]), .out_ready(orr[1]), .sum(sum16), .carry(cy[1]), .overflow(of[1]));
  function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y, input logic s);
    longint ux = longint'(x), uy = longint'(y), one = 1, lim, sx, sy, sr;
    logic c, o;
    logic [15:0] res;
    lim = one << (w - 1);
    sx  = x[w-1] ? ux - 2 * lim : ux;
    sy  = y[w-1] ? uy - 2 * lim : uy;
    sr  = s ? sx - sy : sx + sy;
    o   = sr >= lim || sr < -lim;
    c   = s ? ux >= uy : ux + uy >= 2 * lim;
    res = 16'((s ? ux - uy : ux + uy) & (2 * lim - 1));
`ifdef ADDSUB_SAT_EN
    if (o) res = x[w-1] ? 16'(lim) : 16'(lim - 1);
`endif
    return {res, c, o};
  endfunction
  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ov[0] && orr[0]) begin
      if (q0.size() == 0) chk("unexpected output u8", 1, 0);
      else chk("result u8 {sum,carry,ovf}", {sum_w[0], cy[0], of[0]}, q0.pop_front());
    end
    if (ov[1] && orr[1]) begin
      if (q1.size() == 0) chk("unexpected output u16", 1, 0);
      else chk("result u16 {sum,carry,ovf}", {sum_w[1], cy[1], of[1]}, q1.pop_front());
    end
  end
  task automatic accept(input int i, input logic [15:0] x, input logic [15:0] y, input logic s);
    int t = 0;
    a[i] = x; b[i] = y; sub[i] = s; iv[i] = 1'b1;
    @(negedge clk);
    while (!ir[i] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ir[i]) begin
      chk("accept timeout", 0, 1);
      iv[i] = 1'b0;
      return;
    end
    if (i == 0) q0.push_back(model(8, x, y, s));
    else q1.push_back(model(16, x, y, s));
    @(posedge clk);
    #1 iv[i] = 1'b0;
  endtask
  task automatic wait_out(input int i, input int n_exp, input string nm);
    int lat = 0;
    while (!ov[i] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(nm, lat, n_exp);
  endtask
  task automatic op(input int i, input logic [15:0] x, input logic [15:0] y, input logic s);
    accept(i, x, y, s);
    wait_out(i, i == 0 ? 2 : 16, "latency");
    @(posedge clk);
    #1;
    chk("in_ready after handshake", ir[i], 1);
    chk("out_valid after handshake", ov[i], 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] x, y;
    logic        s;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 0; a[i] = 0; b[i] = 0; sub[i] = 0; orr[i] = 1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset in_ready", ir[i], 1);
      chk("reset out_valid", ov[i], 0);
      chk("reset sum", sum_w[i], 0);
      chk("reset carry", cy[i], 0);
      chk("reset overflow", of[i], 0);
    end
    rst = 0;
    op(0, 16'h05, 16'h02, 0);
    op(0, 16'h05, 16'h03, 1);
    op(0, 16'h7F, 16'h01, 0);
    op(0, 16'h80, 16'h01, 1);
    op(0, 16'hFF, 16'h01, 0);
    orr[0] = 0;
    accept(0, 16'h0B, 16'h02, 0);
    wait_out(0, 2, "bp latency");
    a[0] = 16'h01; b[0] = 16'h01; sub[0] = 0; iv[0] = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp out_valid held", ov[0], 1);
      chk("bp sum held", sum_w[0], 16'h0D);
      chk("bp in_ready low", ir[0], 0);
    end
    orr[0] = 1;
    accept(0, 16'h01, 16'h01, 0);
    wait_out(0, 2, "bp second latency");
    @(posedge clk);
    #1;
    accept(0, 16'h0D, 16'h06, 0);
    void'(q0.pop_back());
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("abort in_ready", ir[0], 1);
    chk("abort out_valid", ov[0], 0);
    chk("abort sum", sum_w[0], 0);
    repeat (4) @(posedge clk);
    #1;
    op(0, 16'h0D, 16'h06, 0);
    op(1, 16'h7FFF, 16'h0001, 0);
    for (int n = 0; n < 30; n++) begin
      x = 16'($urandom_range(0, 255));
      y = 16'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      orr[0] = 0;
      accept(0, x, y, s);
      wait_out(0, 2, "random latency u8");
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
        chk("random stall hold", ov[0], 1);
      end
      orr[0] = 1;
      @(posedge clk);
      #1 orr[0] = 0;
    end
    orr[0] = 1;
    for (int n = 0; n < 8; n++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      s = 1'($urandom_range(0, 1));
      op(1, x, y, s);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("u8 scoreboard drained", q0.size(), 0);
    chk("u16 scoreboard drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
